serial_add_sub: RTL and testbench

//   Multi-cycle, slice-serial WIDTH-bit adder/subtractor with ARM-style NZCV flags and carry-in (ADC/SBC).

---
 rtl/serial_add_sub.sv | 137 +++++++++++++
 tb/tb_serial_add_sub.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - slice-serial add/subtract unit with NZCV flags and carry-in
module serial_add_sub #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_reg_q, carry_reg_d, zacc_q, zacc_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [SLICE-1:0] a_sl, b_sl;
  logic [SLICE:0]   slice_full;
  logic             slice_zero, carry_into_msb;

  always_comb begin
    // Operands shift right so the active slice always sits in the low bits;
    // b is stored already inverted for SUB/SBC.
    a_sl           = a_q[SLICE-1:0];
    b_sl           = b_q[SLICE-1:0];
    slice_full     = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_reg_q);
    slice_zero     = (slice_full[SLICE-1:0] == '0);
    carry_into_msb = slice_full[SLICE-1] ^ a_sl[SLICE-1] ^ b_sl[SLICE-1];

    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    result_d    = result_q;
    k_d         = k_q;
    carry_reg_d = carry_reg_q;
    zacc_d      = zacc_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          a_d         = a;
          b_d         = op[0] ? ~b : b;
          carry_reg_d = op[1] ? cin : op[0];
          k_d         = '0;
          zacc_d      = 1'b1;
          busy_d      = 1'b1;
        end
      end
      RUN: begin
        a_d         = a_q >> SLICE;
        b_d         = b_q >> SLICE;
        sum_d       = (sum_q >> SLICE) | (WIDTH'(slice_full[SLICE-1:0]) << (WIDTH - SLICE));
        carry_reg_d = slice_full[SLICE];
        zacc_d      = zacc_q & slice_zero;
        k_d         = k_q + 1'b1;
        if (k_q == K_LAST) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = sum_d;
          n_d      = slice_full[SLICE-1];
          z_d      = zacc_q & slice_zero;
          c_d      = slice_full[SLICE];
          v_d      = carry_into_msb ^ slice_full[SLICE];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      result_q    <= '0;
      k_q         <= '0;
      carry_reg_q <= 1'b0;
      zacc_q      <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      result_q    <= result_d;
      k_q         <= k_d;
      carry_reg_q <= carry_reg_d;
      zacc_q      <= zacc_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign result   = result_q;
  assign negative = n_q;
  assign zero     = z_q;
  assign carry    = c_q;
  assign overflow = v_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - self-checking bench for serial_add_sub at SLICE 16, 64 and 8
module tb_serial_add_sub;
  logic        clk = 1'b0;
  logic        reset, start, cin;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [63:0] res [3];
  logic        neg [3], zer [3], car [3], ovf [3], bsy [3], dn [3];
  int          checks = 0;
  int          errors = 0;
  int          ns  [3] = '{4, 1, 8};
  int          slw [3] = '{16, 64, 8};

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] res;
    logic [3:0]  nzcv;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(64), .SLICE(16)) u16 (.clk(clk), .reset(reset), .start(start), .op(op),
    .cin(cin), .a(a), .b(b), .result(res[0]), .negative(neg[0]), .zero(zer[0]), .carry(car[0]),
    .overflow(ovf[0]), .busy(bsy[0]), .done(dn[0]));
  serial_add_sub #(.WIDTH(64), .SLICE(64)) u64 (.clk(clk), .reset(reset), .start(start), .op(op),
    .cin(cin), .a(a), .b(b), .result(res[1]), .negative(neg[1]), .zero(zer[1]), .carry(car[1]),
    .overflow(ovf[1]), .busy(bsy[1]), .done(dn[1]));
  serial_add_sub #(.WIDTH(64), .SLICE(8)) u8 (.clk(clk), .reset(reset), .start(start), .op(op),
    .cin(cin), .a(a), .b(b), .result(res[2]), .negative(neg[2]), .zero(zer[2]), .carry(car[2]),
    .overflow(ovf[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, flags derived from operand/result signs.
  function automatic logic [67:0] model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                        input logic ci);
    logic [63:0] yy;
    logic        c0, v;
    logic [64:0] full;
    yy   = o[0] ? ~y : y;
    c0   = o[1] ? ci : o[0];
    full = {1'b0, x} + {1'b0, yy} + 65'(c0);
    v    = (x[63] == yy[63]) && (full[63] != x[63]);
    return {full[63], full[63:0] == 64'd0, full[64], v, full[63:0]};
  endfunction

  function automatic logic [3:0] nzcv(input int i);
    return {neg[i], zer[i], car[i], ovf[i]};
  endfunction

  task automatic do_op(input string name, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                       input logic ci, input logic [67:0] exp);
    int first [3];
    int pulses [3];
    for (int i = 0; i < 3; i++) begin first[i] = -1; pulses[i] = 0; end
    @(negedge clk);
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y; cin = ~ci;
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          pulses[i]++;
          if (first[i] < 0) begin
            first[i] = c - 1;
            chk($sformatf("%s/s%0d result", name, slw[i]), res[i], exp[63:0]);
            chk($sformatf("%s/s%0d nzcv", name, slw[i]), 64'(nzcv(i)), 64'(exp[67:64]));
          end
        end
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s/s%0d latency", name, slw[i]), 64'(first[i]), 64'(ns[i]));
      chk($sformatf("%s/s%0d done_pulses", name, slw[i]), 64'(pulses[i]), 64'd1);
    end
  endtask

  initial begin
    logic [63:0] x, y, last_res;
    logic [1:0]  o;
    logic        ci;
    logic [67:0] exp;
    int          pulses, last, got;

    tbl[0] = '{2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    tbl[1] = '{2'b01, 64'd5, 64'd5, 1'b0, 64'd0, 4'b0110};
    tbl[2] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    tbl[3] = '{2'b11, 64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    tbl[4] = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 4'b0110};
    tbl[5] = '{2'b00, 64'd3, 64'd4, 1'b1, 64'd7, 4'b0000};
    tbl[6] = '{2'b01, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000};
    tbl[7] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};

    reset = 1'b1; start = 1'b0; op = 2'b00; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("reset%0d/s%0d result", r, slw[i]), res[i], 64'd0);
        chk($sformatf("reset%0d/s%0d flags", r, slw[i]), 64'({nzcv(i), bsy[i], dn[i]}), 64'd0);
      end
    end

    for (int t = 0; t < 8; t++)
      do_op($sformatf("vec%0d", t), tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].cin, {tbl[t].nzcv, tbl[t].res});

    for (int t = 0; t < 10; t++) begin
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
      o = 2'($urandom_range(0, 3)); ci = 1'($urandom_range(0, 1));
      if (t == 0) y = ~x;
      do_op($sformatf("rand%0d", t), o, x, y, ci, model(o, x, y, ci));
    end

    // start pulsed while busy must not disturb the running operation
    @(negedge clk);
    op = 2'b00; a = 64'd100; b = 64'd23; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 64'hDEAD; b = 64'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_during_run", 64'(bsy[0]), 64'd1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (dn[0]) begin
        pulses++;
        chk("busy_start result", res[0], 64'd123);
      end
      @(negedge clk);
    end
    chk("busy_start done_pulses", 64'(pulses), 64'd1);
    repeat (12) @(negedge clk);

    // start held high: one result every NSLICE+1 edges
    x = {$urandom, $urandom}; y = {$urandom, $urandom}; o = 2'($urandom_range(0, 3)); ci = 1'($urandom_range(0, 1));
    exp = model(o, x, y, ci);
    @(negedge clk);
    op = o; a = x; b = y; cin = ci; start = 1'b1;
    last = -1; got = 0;
    for (int c = 0; c < 40 && got < 3; c++) begin
      @(negedge clk);
      if (dn[0]) begin
        chk($sformatf("b2b%0d result", got), res[0], exp[63:0]);
        chk($sformatf("b2b%0d nzcv", got), 64'(nzcv(0)), 64'(exp[67:64]));
        if (last >= 0) chk($sformatf("b2b%0d spacing", got), 64'(c - last), 64'd5);
        last = c; got++;
        x = {$urandom, $urandom}; y = {$urandom, $urandom};
        o = 2'($urandom_range(0, 3)); ci = 1'($urandom_range(0, 1));
        exp = model(o, x, y, ci);
        op = o; a = x; b = y; cin = ci;
      end
    end
    start = 1'b0;
    chk("b2b count", 64'(got), 64'd3);
    repeat (12) @(negedge clk);

    // reset in the middle of a run
    last_res = res[0];
    @(negedge clk);
    op = 2'b00; a = 64'd1000; b = 64'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midreset/s%0d result", slw[i]), res[i], 64'd0);
      chk($sformatf("midreset/s%0d flags", slw[i]), 64'({nzcv(i), bsy[i], dn[i]}), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (dn[i]) pulses++;
    end
    chk("midreset done_pulses", 64'(pulses), 64'd0);
    chk("midreset result_held_zero", res[0] | (last_res & 64'd0), 64'd0);
    do_op("after_reset", 2'b00, 64'd3, 64'd4, 1'b0, {4'b0000, 64'd7});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
